seg_counter_n: RTL and testbench
================================

Name: seg_counter_n

Overview:
- Parametrised N-digit seven-segment up/down counter; next generation of the board's two-digit hex display counter.
- Adds the following:
  - configurable digit count, radix (hex or BCD), polarity and tick period;
  - up/down direction, enable/pause, parallel load and manual step;
  - wrap pulse and optional leading-zero blanking.
- Sits at top level, driving the display pins directly. It can also be cascaded via o_Wrap.

Parameters:
- NUM_DIGITS, 2: number of displayed digits, 1..4.
- TICK_PERIOD, 25000000: i_Clk cycles per automatic count step, >=2.
- RADIX, 16: 16 = hex digits, 10 = BCD digits. Any other value is illegal; elaboration check fails.
- ACTIVE_LOW, 1: 1 = segment pin low lights the segment (Go Board); 0 = high lights it.
- BLANK_LZ, 0: 1 = blank leading zero digits.

Ports:
- i_Clk, in, 1: clock.
- rst, in, 1: reset.
- i_En, in, 1: enables automatic counting. Prescaler holds its value when low.
- i_Up, in, 1: 1 = count up, 0 = count down. Sampled at each step.
- i_Step, in, 1: single-cycle manual step request. Honoured regardless of i_En.
- i_Load, in, 1: load i_Load_Val into the counter.
- i_Load_Val, in, 4*NUM_DIGITS: load value, one nibble per digit, digit0 = [3:0].
- o_Count, out, 4*NUM_DIGITS: current count, one nibble per digit.
- o_Wrap, out, 1: one-cycle pulse on wrap-around.
- o_Segments, out, 7*NUM_DIGITS: segment pins. Digit k occupies [7k+6:7k], ordered a..g with a at the MSB.

Behaviour:
- Reset and clocking: reset rst, synchronous, active-high; clock i_Clk. All state updates on posedge i_Clk.
- Reset values:
  - prescaler = 0, o_Count = 0, o_Wrap = 0.
  - o_Segments = encoding of count 0: digit0 shows "0"; higher digits show "0", or are blank if BLANK_LZ=1. ACTIVE_LOW polarity applies.
- Prescaler:
  - While i_En=1, increments each cycle from 0 to TICK_PERIOD-1, then returns to 0.
  - tick is asserted combinationally when prescaler==TICK_PERIOD-1 and i_En=1.
  - Automatic steps are therefore TICK_PERIOD cycles apart.
- Step event = tick OR i_Step. A coincident tick and i_Step produce exactly one step, not two.
- Priority is rst > i_Load > step:
  - i_Load=1: o_Count <= i_Load_Val on the next edge, prescaler <= 0, o_Wrap <= 0. Any step in that cycle is discarded.
  - In RADIX=10, any load nibble > 9 is clamped to 9 per digit.
- Up step:
  - digit0 increments.
  - A digit at RADIX-1 goes to 0 and carries into the next digit.
  - Carry out of the top digit (count was all RADIX-1) wraps to all zeros and sets o_Wrap=1 for exactly one cycle, aligned with the new o_Count.
- Down step:
  - Mirror of the up step with borrow.
  - A digit at 0 goes to RADIX-1.
  - All zeros wraps to all RADIX-1 and sets o_Wrap=1.
- o_Count latency: updates 1 cycle after the step/load input edge.
- o_Segments latency: registered decode, 1 cycle after o_Count (2 cycles from the step).
- Decode table (abcdefg, active-high form):
  - 0: 7E, 1: 30, 2: 6D, 3: 79
  - 4: 33, 5: 5B, 6: 5F, 7: 70
  - 8: 7F, 9: 7B, A: 77, b: 1F
  - C: 4E, d: 3D, E: 4F, F: 47
  - If ACTIVE_LOW=1, output is the bitwise inverse.
- Blanking:
  - With BLANK_LZ=1, digit k>0 is blank (all segments off) when it and all higher digits are 0.
  - digit0 is never blanked.
- Direction change: i_Up may change at any time. It takes effect at the next step with no extra latency and no spurious wrap.
- i_En low mid-period: prescaler freezes and resumes from the same value. Counting is paused, not restarted.
- Reset mid-operation: all state returns to reset values on the next edge, including a pending o_Wrap.

Test Plan:
- Reset, then TICK_PERIOD=4, RADIX=16, NUM_DIGITS=2, i_En=1, i_Up=1 for 40 cycles -> o_Count steps every 4 cycles: 00,01,..,09,0A. Segment digit0 for "A" = ~7'h77 = 7'h08. Segments lag o_Count by 1 cycle.
- Load 8'hFE, up steps -> FF, then 00 with o_Wrap high for exactly 1 cycle, then 01 with o_Wrap low.
- RADIX=10, load 8'h09, up step -> 10 (BCD carry). Load 8'h00, down step -> 99 with o_Wrap=1. Load 8'hAF -> o_Count=99 (clamp).
- i_En=0 with i_Step pulses at cycles 3 and 7 -> exactly two steps, prescaler stays 0. i_Step coincident with tick -> single increment.
- BLANK_LZ=1, count 05 -> digit1 all off (7'h7F when active-low), digit0 = ~7'h5B. Count 00 -> digit0 shows "0", digit1 blank.
- Assert rst while count=37 and mid-period, in the same cycle as i_Load -> next edge o_Count=00, prescaler=0, o_Wrap=0. Load is ignored.

Source files
------------

// File: rtl/seg_counter_n.sv
// N-digit seven-segment up/down counter with hex or BCD digits, a free-running
// step prescaler, parallel load, manual step, wrap pulse and leading-zero blanking.
module seg_counter_n #(
  parameter int NUM_DIGITS  = 2,
  parameter int TICK_PERIOD = 25000000,
  parameter int RADIX       = 16,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LZ    = 0
) (
  input  logic                      i_Clk,
  input  logic                      rst,
  input  logic                      i_En,
  input  logic                      i_Up,
  input  logic                      i_Step,
  input  logic                      i_Load,
  input  logic [4*NUM_DIGITS-1:0]   i_Load_Val,
  output logic [4*NUM_DIGITS-1:0]   o_Count,
  output logic                      o_Wrap,
  output logic [7*NUM_DIGITS-1:0]   o_Segments
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int SW = 7 * NUM_DIGITS;
  localparam int PW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [3:0] DMAX = 4'(RADIX - 1);

  if (RADIX != 10 && RADIX != 16) begin : g_bad_radix
    $error("seg_counter_n: RADIX must be 10 or 16");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_bad_digits
    $error("seg_counter_n: NUM_DIGITS must be 1..4");
  end
  if (TICK_PERIOD < 2) begin : g_bad_tick
    $error("seg_counter_n: TICK_PERIOD must be >= 2");
  end

  // Active-high abcdefg pattern, a at bit 6.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  // Walk from the top digit down so "this and all higher digits are zero" accumulates.
  function automatic logic [SW-1:0] encode_count(input logic [CW-1:0] c);
    logic [SW-1:0] seg;
    logic          upper_zero;
    logic [6:0]    s;
    seg        = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (c[4*k +: 4] == 4'd0);
      s = decode_digit(c[4*k +: 4]);
      if (BLANK_LZ != 0 && k > 0 && upper_zero) s = 7'h00;
      if (ACTIVE_LOW != 0) s = ~s;
      seg[7*k +: 7] = s;
    end
    return seg;
  endfunction

  // Returns {carry_out, stepped_count}; carry_out means the whole count wrapped.
  function automatic logic [CW:0] step_count(input logic [CW-1:0] c, input logic up);
    logic [CW-1:0] r;
    logic          carry;
    logic [3:0]    d;
    r     = c;
    carry = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = c[4*k +: 4];
      if (carry) begin
        if (up) begin
          if (d == DMAX) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*k +: 4] = DMAX;
          end else begin
            r[4*k +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    return {carry, r};
  endfunction

  function automatic logic [CW-1:0] clamp_load(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    if (RADIX == 10) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] seg_q;
  logic          tick;
  logic          step_ev;
  logic [CW:0]   stepped;

  assign tick    = i_En && (presc_q == PW'(TICK_PERIOD - 1));
  assign step_ev = tick || i_Step;
  assign stepped = step_count(count_q, i_Up);

  // Load wins over any step in the same cycle and restarts the tick period.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (i_Load) begin
      count_d = clamp_load(i_Load_Val);
      presc_d = '0;
    end else begin
      if (i_En) presc_d = tick ? '0 : presc_q + PW'(1);
      if (step_ev) begin
        count_d = stepped[CW-1:0];
        wrap_d  = stepped[CW];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= encode_count('0);
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      seg_q   <= encode_count(count_q);
    end
  end

  assign o_Count    = count_q;
  assign o_Wrap     = wrap_q;
  assign o_Segments = seg_q;

endmodule

// File: tb/tb_seg_counter_n.sv
// Directed bench for seg_counter_n: a hex instance and a BCD instance with
// leading-zero blanking, checked against hand-computed values by cycle.
module tb_seg_counter_n;

  localparam int EW = 25;  // {dut, count[7:0], wrap, seg[13:0], seg_check}

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_b = 1'b0;
  logic       i_En = 1'b0, i_Up = 1'b1, i_Step = 1'b0, i_Load = 1'b0;
  logic [7:0] i_Load_Val = 8'h00;

  logic [7:0]  h_count, b_count;
  logic        h_wrap, b_wrap;
  logic [13:0] h_seg, b_seg;
  logic        rst_h, rst_b;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  int             exp_cyc_q[$];
  logic [EW-1:0]  exp_q[$];

  // Active-low patterns for 0..F, blank is 7'h7F.
  logic [6:0] seg_al [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  assign rst_h = rst | sel_b;
  assign rst_b = rst | ~sel_b;

  seg_counter_n #(.NUM_DIGITS(2), .TICK_PERIOD(4), .RADIX(16), .ACTIVE_LOW(1), .BLANK_LZ(0))
  dut_h (
    .i_Clk(clk), .rst(rst_h), .i_En(i_En), .i_Up(i_Up), .i_Step(i_Step),
    .i_Load(i_Load), .i_Load_Val(i_Load_Val),
    .o_Count(h_count), .o_Wrap(h_wrap), .o_Segments(h_seg)
  );

  seg_counter_n #(.NUM_DIGITS(2), .TICK_PERIOD(4), .RADIX(10), .ACTIVE_LOW(1), .BLANK_LZ(1))
  dut_b (
    .i_Clk(clk), .rst(rst_b), .i_En(i_En), .i_Up(i_Up), .i_Step(i_Step),
    .i_Load(i_Load), .i_Load_Val(i_Load_Val),
    .o_Count(b_count), .o_Wrap(b_wrap), .o_Segments(b_seg)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expect (count, wrap, shown value) d cycles from now on the selected instance.
  task automatic exp_at(input int d, input logic [7:0] cnt, input logic w,
                        input logic [7:0] shown, input logic cs);
    logic [6:0] s1, s0;
    s0 = seg_al[shown[3:0]];
    s1 = seg_al[shown[7:4]];
    if (sel_b && shown[7:4] == 4'd0) s1 = 7'h7F;
    exp_cyc_q.push_back(cyc + d);
    exp_q.push_back({sel_b, cnt, w, s1, s0, cs});
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    int            t;
    logic [EW-1:0] e;
    logic [7:0]    a_cnt;
    logic          a_wrap;
    logic [13:0]   a_seg;
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      t = exp_cyc_q.pop_front();
      e = exp_q.pop_front();
      a_cnt  = e[24] ? b_count : h_count;
      a_wrap = e[24] ? b_wrap  : h_wrap;
      a_seg  = e[24] ? b_seg   : h_seg;
      n_checks++;
      if (t != cyc) begin
        $display("FAIL stale_entry cyc=%0d: expectation for cyc %0d not checked in time", cyc, t);
      end else if (a_cnt == e[23:16]) n_pass++;
      else $display("FAIL count dut=%0d cyc=%0d: got %h expected %h", e[24], cyc, a_cnt, e[23:16]);
      n_checks++;
      if (a_wrap == e[15]) n_pass++;
      else $display("FAIL wrap dut=%0d cyc=%0d: got %b expected %b", e[24], cyc, a_wrap, e[15]);
      if (e[0]) begin
        n_checks++;
        if (a_seg == e[14:1]) n_pass++;
        else $display("FAIL segments dut=%0d cyc=%0d: got %h expected %h", e[24], cyc, a_seg, e[14:1]);
      end
    end
  end

  initial begin
    int c0, c1, s, r, b;

    // Reset state of the hex instance
    cycles(2);
    exp_at(0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Free-running count, segments lag count by one cycle
    c0 = cyc;
    rst = 1'b0; i_En = 1'b1; i_Up = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      exp_at(4*n,     8'(n), 1'b0, 8'(n-1), 1'b1);
      exp_at(4*n + 1, 8'(n), 1'b0, 8'(n),   1'b1);
    end
    cycles(41);

    // Load FE then manual steps through the wrap
    c1 = cyc;
    i_En = 1'b0; i_Load = 1'b1; i_Load_Val = 8'hFE;
    exp_at(1, 8'hFE, 1'b0, 8'h0A, 1'b1);
    exp_at(2, 8'hFF, 1'b0, 8'hFE, 1'b1);
    exp_at(3, 8'h00, 1'b1, 8'hFF, 1'b1);
    exp_at(4, 8'h01, 1'b0, 8'h00, 1'b1);
    exp_at(5, 8'h01, 1'b0, 8'h01, 1'b1);
    cycles(1); i_Load = 1'b0; i_Step = 1'b1;
    cycles(3); i_Step = 1'b0;

    // Manual steps while disabled, coincident step+tick, pause, direction change
    s = cyc;
    exp_at(4,  8'h02, 1'b0, 8'h00, 1'b0);
    exp_at(7,  8'h02, 1'b0, 8'h00, 1'b0);
    exp_at(8,  8'h03, 1'b0, 8'h00, 1'b0);
    exp_at(10, 8'h03, 1'b0, 8'h00, 1'b0);
    exp_at(13, 8'h03, 1'b0, 8'h00, 1'b0);
    exp_at(14, 8'h04, 1'b0, 8'h00, 1'b0);
    exp_at(18, 8'h05, 1'b0, 8'h00, 1'b0);
    exp_at(19, 8'h05, 1'b0, 8'h05, 1'b1);
    exp_at(22, 8'h06, 1'b0, 8'h00, 1'b0);
    exp_at(31, 8'h06, 1'b0, 8'h00, 1'b0);
    exp_at(32, 8'h07, 1'b0, 8'h00, 1'b0);
    exp_at(36, 8'h06, 1'b0, 8'h00, 1'b0);
    cycles(3); i_Step = 1'b1;
    cycles(1); i_Step = 1'b0;
    cycles(3); i_Step = 1'b1;
    cycles(1); i_Step = 1'b0;
    cycles(2); i_En = 1'b1;
    cycles(7); i_Step = 1'b1;
    cycles(1); i_Step = 1'b0;
    cycles(6); i_En = 1'b0;
    cycles(6); i_En = 1'b1;
    cycles(2); i_Up = 1'b0;
    cycles(4); i_En = 1'b0;

    // Reset mid-period together with a load
    r = cyc;
    i_Load = 1'b1; i_Load_Val = 8'h37; i_En = 1'b1;
    exp_at(1, 8'h37, 1'b0, 8'h00, 1'b0);
    exp_at(3, 8'h00, 1'b0, 8'h00, 1'b1);
    exp_at(6, 8'h00, 1'b0, 8'h00, 1'b0);
    exp_at(7, 8'h01, 1'b0, 8'h00, 1'b0);
    cycles(1); i_Load = 1'b0;
    cycles(1); rst = 1'b1; i_Load = 1'b1; i_Load_Val = 8'h99; i_Up = 1'b1;
    cycles(1); rst = 1'b0; i_Load = 1'b0;
    cycles(4); i_En = 1'b0;

    // BCD instance with blanking
    b = cyc;
    sel_b = 1'b1; i_Up = 1'b1;
    cycles(1);
    exp_at(0, 8'h00, 1'b0, 8'h00, 1'b1);
    exp_at(1, 8'h09, 1'b0, 8'h00, 1'b0);
    i_Load = 1'b1; i_Load_Val = 8'h09;
    cycles(1); i_Load = 1'b0; i_Step = 1'b1;
    exp_at(1, 8'h10, 1'b0, 8'h09, 1'b1);
    exp_at(2, 8'h10, 1'b0, 8'h10, 1'b1);
    cycles(1); i_Step = 1'b0;
    cycles(1); i_Load = 1'b1; i_Load_Val = 8'h00;
    exp_at(1, 8'h00, 1'b0, 8'h00, 1'b0);
    cycles(1); i_Load = 1'b0; i_Up = 1'b0; i_Step = 1'b1;
    exp_at(1, 8'h99, 1'b1, 8'h00, 1'b0);
    exp_at(2, 8'h99, 1'b0, 8'h99, 1'b1);
    cycles(1); i_Step = 1'b0;
    cycles(1); i_Load = 1'b1; i_Load_Val = 8'hAF;
    exp_at(1, 8'h99, 1'b0, 8'h00, 1'b0);
    cycles(1); i_Load_Val = 8'h05;
    exp_at(1, 8'h05, 1'b0, 8'h00, 1'b0);
    exp_at(2, 8'h05, 1'b0, 8'h05, 1'b1);
    cycles(1); i_Load = 1'b0;
    cycles(1); i_Load = 1'b1; i_Load_Val = 8'h3C; i_Step = 1'b1; i_Up = 1'b1;
    exp_at(1, 8'h39, 1'b0, 8'h00, 1'b0);
    cycles(1); i_Load_Val = 8'h00;
    exp_at(1, 8'h00, 1'b0, 8'h00, 1'b0);
    cycles(1); i_Load = 1'b0; i_Step = 1'b0;
    cycles(1);
    exp_at(0, 8'h00, 1'b0, 8'h00, 1'b1);
    exp_at(1, 8'h99, 1'b0, 8'h00, 1'b0);
    i_Load = 1'b1; i_Load_Val = 8'h99;
    cycles(1); i_Load = 1'b0; i_Step = 1'b1;
    exp_at(1, 8'h00, 1'b1, 8'h99, 1'b1);
    exp_at(2, 8'h00, 1'b0, 8'h00, 1'b1);
    cycles(1); i_Step = 1'b0;
    cycles(3);

    // Final report
    while (exp_cyc_q.size() > 0) begin
      void'(exp_cyc_q.pop_front());
      void'(exp_q.pop_front());
      n_checks++;
      $display("FAIL unchecked_entry: got pending expectation, required none at end");
    end
    if (b < c0 || r < c1 || s < c1) $display("FAIL sequencing: phase order broken");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
